// File: rtl/timer_pkg.sv
// Shared types for the PWM dead-time generator: FSM state encoding and the
// compare/dead-time configuration record used for staging and active values.
package timer_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    LOW  = 3'd1,
    DT_H = 3'd2,
    HIGH = 3'd3,
    DT_L = 3'd4
  } pwm_state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]    cmp;
    logic [DT_WIDTH_DEF-1:0] dead;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Double-buffered compare/dead-time registers: software stages with upd_req,
// the staged pair is copied to the active pair on a period boundary and acked.
module pwm_shadow_reg
  import timer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    cmp_in,
  input  logic [DT_WIDTH-1:0] dead_in,
  input  logic                upd_req,
  input  logic                done,
  output logic [WIDTH-1:0]    cmp_act,
  output logic [DT_WIDTH-1:0] dead_act,
  output logic                upd_busy,
  output logic                upd_ack
);

  // Field widths come from the package; WIDTH/DT_WIDTH must stay equal to them.
  pwm_cfg_t stage;
  pwm_cfg_t act;
  logic     pending;
  logic     apply;

  assign apply = done && pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage   <= '0;
      act     <= '0;
      pending <= 1'b0;
      upd_ack <= 1'b0;
    end else begin
      upd_ack <= apply;
      if (apply) begin
        act <= stage;
      end
      // A request coinciding with the boundary is captured after the old
      // staging has been applied, so it stays pending for the next boundary.
      if (upd_req) begin
        stage   <= '{cmp: cmp_in, dead: dead_in};
        pending <= 1'b1;
      end else if (done) begin
        pending <= 1'b0;
      end
    end
  end

  assign cmp_act  = act.cmp;
  assign dead_act = act.dead;
  assign upd_busy = pending;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM pair from a down-counter compare, with programmable dead
// time between the high and low sides; config changes land on period edges.
module pwm_deadtime_gen
  import timer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WIDTH-1:0]    count,
  input  logic                done,
  input  logic [WIDTH-1:0]    cmp_in,
  input  logic [DT_WIDTH-1:0] dead_in,
  input  logic                upd_req,
  output logic                upd_busy,
  output logic                upd_ack,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                period_irq,
  output logic [2:0]          state_o
);

  logic [WIDTH-1:0]    cmp_act;
  logic [DT_WIDTH-1:0] dead_act;
  logic                ref_q;
  logic [DT_WIDTH-1:0] dt_cnt;
  logic [DT_WIDTH:0]   dt_cnt_inc;
  logic                dt_done;
  logic                dead_zero;
  pwm_state_t          state;
  pwm_state_t          state_nxt;

  pwm_shadow_reg #(
    .WIDTH    (WIDTH),
    .DT_WIDTH (DT_WIDTH)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .cmp_in   (cmp_in),
    .dead_in  (dead_in),
    .upd_req  (upd_req),
    .done     (done),
    .cmp_act  (cmp_act),
    .dead_act (dead_act),
    .upd_busy (upd_busy),
    .upd_ack  (upd_ack)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q      <= 1'b0;
      period_irq <= 1'b0;
    end else begin
      ref_q      <= en && (count < cmp_act);
      period_irq <= done && en;
    end
  end

  // dt_cnt+1 >= dead_act, evaluated one bit wider so dead_act=0 (possible
  // after a mid-phase update) exits immediately instead of wrapping.
  assign dt_cnt_inc = {1'b0, dt_cnt} + {{DT_WIDTH{1'b0}}, 1'b1};
  assign dt_done    = dt_cnt_inc >= {1'b0, dead_act};
  assign dead_zero  = (dead_act == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:  state_nxt = dead_zero ? LOW : DT_L;
      LOW:  if (ref_q)  state_nxt = dead_zero ? HIGH : DT_H;
      DT_H: begin
        if (!ref_q)       state_nxt = LOW;
        else if (dt_done) state_nxt = HIGH;
      end
      HIGH: if (!ref_q) state_nxt = dead_zero ? LOW : DT_L;
      DT_L: begin
        if (ref_q)        state_nxt = HIGH;
        else if (dt_done) state_nxt = LOW;
      end
      default: state_nxt = OFF;
    endcase
    if (!en) begin
      state_nxt = OFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= OFF;
      dt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        dt_cnt <= '0;
      end else if (state == DT_H || state == DT_L) begin
        dt_cnt <= dt_cnt_inc[DT_WIDTH-1:0];
      end
    end
  end

  // Moore decode straight off the state register, so an async reset drops
  // both drives without waiting for a clock edge.
  assign pwm_h   = (state == HIGH);
  assign pwm_l   = (state == LOW);
  assign state_o = state;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench: a 16-cycle down-counter (15..0, done at 0) drives the PWM;
// per-period output masks are compared with hand-derived patterns.
module tb_pwm_deadtime_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] count;
  logic        done;
  logic [15:0] cmp_in;
  logic [7:0]  dead_in;
  logic        upd_req;
  logic        upd_busy;
  logic        upd_ack;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_irq;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  int ack_mark;
  logic [15:0] hv, lv, dv;

  pwm_deadtime_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .count      (count),
    .done       (done),
    .cmp_in     (cmp_in),
    .dead_in    (dead_in),
    .upd_req    (upd_req),
    .upd_busy   (upd_busy),
    .upd_ack    (upd_ack),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .period_irq (period_irq),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(pwm_h && pwm_l)) else $error("FAIL overlap: pwm_h=%0b pwm_l=%0b", pwm_h, pwm_l);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the down-counter, end any one-cycle request pulse.
  task automatic cyc();
    @(posedge clk);
    #1;
    upd_req = 1'b0;
    count   = (count == 16'd0) ? 16'd15 : count - 16'd1;
    done    = (count == 16'd0);
    ack_cnt += int'(upd_ack);
  endtask

  task automatic sync_to(input int c);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (int'(count) != c && n < 40);
    chk("sync", 32'(count), 32'(c));
  endtask

  task automatic run_period(output logic [15:0] h, output logic [15:0] l, output logic [15:0] d);
    h = '0; l = '0; d = '0;
    repeat (16) begin
      cyc();
      h[count[3:0]] = pwm_h;
      l[count[3:0]] = pwm_l;
      d[count[3:0]] = (state_o == 3'd2);
    end
  endtask

  task automatic stage(input logic [15:0] c, input logic [7:0] d);
    cmp_in  = c;
    dead_in = d;
    upd_req = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; count = 16'd15; done = 1'b0;
    cmp_in = '0; dead_in = '0; upd_req = 1'b0;
    #23;
    chk("rst_pwm_h", 32'(pwm_h), 0);
    chk("rst_pwm_l", 32'(pwm_l), 0);
    chk("rst_busy", 32'(upd_busy), 0);
    chk("rst_ack", 32'(upd_ack), 0);
    chk("rst_irq", 32'(period_irq), 0);
    chk("rst_state", 32'(state_o), 0);

    // Test 1: cmp=4, dead=2
    @(posedge clk); #1;
    reset = 1'b1;
    stage(16'd4, 8'd2);
    cyc();
    chk("t1_state_low", 32'(state_o), 1);
    chk("t1_busy", 32'(upd_busy), 1);
    sync_to(0);
    chk("t1_busy_done", 32'(upd_busy), 1);
    ack_mark = ack_cnt;
    cyc();
    chk("t1_ack", 32'(upd_ack), 1);
    chk("t1_busy_clr", 32'(upd_busy), 0);
    chk("t1_irq", 32'(period_irq), 1);
    run_period(hv, lv, dv);
    chk("t1_ack_once", 32'(ack_cnt - ack_mark), 1);
    chk("t1_trans_h", 32'(hv), 32'h8000);
    chk("t1_trans_l", 32'(lv), 32'h7FFC);
    run_period(hv, lv, dv);
    chk("t1_h", 32'(hv), 32'hC000);
    chk("t1_l", 32'(lv), 32'h0FFC);
    chk("t1_dth", 32'(dv), 32'h0003);

    // Test 2: cmp=0 then cmp=0xFFFF
    stage(16'd0, 8'd2);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    chk("t2_cmp0_h", 32'(hv), 32'h0000);
    chk("t2_cmp0_l", 32'(lv), 32'hFFFF);
    stage(16'hFFFF, 8'd2);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    chk("t2_full_entry_h", 32'(hv), 32'h8FFF);
    chk("t2_full_entry_l", 32'(lv), 32'h4000);
    run_period(hv, lv, dv);
    chk("t2_full_h", 32'(hv), 32'hFFFF);
    chk("t2_full_l", 32'(lv), 32'h0000);

    // Test 3: dead=5 with a 2-cycle ref pulse
    stage(16'd2, 8'd5);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    chk("t3_h", 32'(hv), 32'h0000);
    chk("t3_l", 32'(lv), 32'h3FFF);
    chk("t3_dth", 32'(dv), 32'hC000);

    // Test 4a: two requests before one boundary
    stage(16'd3, 8'd2);
    cyc();
    stage(16'd7, 8'd2);
    cyc();
    chk("t4_busy", 32'(upd_busy), 1);
    ack_mark = ack_cnt;
    sync_to(15);
    chk("t4_one_ack", 32'(ack_cnt - ack_mark), 1);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    chk("t4_h", 32'(hv), 32'hC007);
    chk("t4_l", 32'(lv), 32'h0FE0);

    // Test 4b: request coincident with done
    stage(16'd4, 8'd2);
    sync_to(0);
    chk("t4_co_busy", 32'(upd_busy), 1);
    stage(16'd7, 8'd2);
    cyc();
    chk("t4_co_ack", 32'(upd_ack), 1);
    chk("t4_co_busy1", 32'(upd_busy), 1);
    cyc();
    chk("t4_co_ack0", 32'(upd_ack), 0);
    sync_to(0);
    cyc();
    chk("t4_co_ack2", 32'(upd_ack), 1);
    chk("t4_co_busy0", 32'(upd_busy), 0);
    run_period(hv, lv, dv);
    run_period(hv, lv, dv);
    chk("t4_co_h", 32'(hv), 32'hC007);
    chk("t4_co_l", 32'(lv), 32'h0FE0);

    // Test 5: drop en in HIGH, re-enable with dead=3
    sync_to(1);
    chk("t5_high", 32'(state_o), 3);
    en = 1'b0;
    cyc();
    chk("t5_off", 32'(state_o), 0);
    chk("t5_off_h", 32'(pwm_h), 0);
    chk("t5_off_l", 32'(pwm_l), 0);
    cyc();
    chk("t5_irq_masked", 32'(period_irq), 0);
    stage(16'd7, 8'd3);
    sync_to(15);
    chk("t5_ack", 32'(upd_ack), 1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_dtl", 32'(state_o), 4);
    end
    cyc();
    chk("t5_low", 32'(pwm_l), 1);

    // Test 6: async reset between edges while HIGH
    sync_to(0);
    chk("t6_high", 32'(pwm_h), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_pwm_h", 32'(pwm_h), 0);
    chk("t6_pwm_l", 32'(pwm_l), 0);
    chk("t6_state", 32'(state_o), 0);
    chk("t6_busy", 32'(upd_busy), 0);
    chk("t6_ack", 32'(upd_ack), 0);
    chk("t6_irq", 32'(period_irq), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream consumer of the prescaled down-counter (`reverse_counter`).
- Takes its running count (`new_count`) and period-boundary pulse (`done`), compares the count against a compare value, and drives a complementary high-side/low-side PWM pair with programmable dead time.
- Compare and dead-time values are double-buffered and applied only at period boundaries.
- A small request/acknowledge handshake lets software stage new values safely.

Parameters:
- WIDTH, 16, width of count and compare values (matches `new_count`).
- DT_WIDTH, 8, width of dead-time value, in clk cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  output enable; 0 forces both outputs low
- count  input  WIDTH  running count from the down-counter (`new_count`)
- done  input  1  one-cycle period-boundary pulse from the down-counter
- cmp_in  input  WIDTH  staged compare value
- dead_in  input  DT_WIDTH  staged dead time, in clk cycles
- upd_req  input  1  one-cycle pulse: capture `cmp_in`/`dead_in` into staging
- upd_busy  output  1  staged update pending, not yet applied
- upd_ack  output  1  one-cycle pulse: staged values applied
- pwm_h  output  1  high-side drive
- pwm_l  output  1  low-side drive
- period_irq  output  1  one-cycle pulse, registered copy of `done` while `en`=1
- state_o  output  3  current FSM state (debug)

Behaviour:
- Reset (`reset`=0, async): all registers clear.
  - cmp_act=0, dead_act=0, staging=0.
  - upd_busy=0, upd_ack=0, period_irq=0.
  - State is OFF, so pwm_h=0 and pwm_l=0.
- Staging handshake:
  - `upd_req`=1 loads staging from `cmp_in`/`dead_in` and sets pending.
  - A request while pending overwrites staging; latest value wins.
  - `upd_busy` is the pending bit.
- Apply at boundary:
  - On `done`=1 with pending=1: cmp_act<=staging.cmp, dead_act<=staging.dead, pending cleared, `upd_ack`=1 the next cycle.
  - If `upd_req` and `done` occur in the same cycle: the old staging is applied and acked, the new value is captured, and pending stays 1 for the next `done`.
  - `done` with pending=0: no change and no ack.
- ref_q (registered): ref_q <= en && (count < cmp_act). This adds one cycle of latency after `count`.
  - cmp_act=0: ref_q is never high, so the low side stays on continuously.
  - cmp_act greater than the reload value: ref_q is always high.
- FSM (registered state, Moore outputs) with states OFF, LOW, DT_H, HIGH, DT_L:
  - OFF: both outputs 0. When `en`=1: go to DT_L, or to LOW if dead_act=0.
  - LOW: pwm_l=1. When ref_q=1: go to DT_H, or to HIGH if dead_act=0.
  - DT_H: both 0.
    - If ref_q=0: go to LOW (glitch suppression, no high pulse).
    - Else if dt_cnt >= dead_act-1: go to HIGH.
    - Else dt_cnt increments.
  - HIGH: pwm_h=1. When ref_q=0: go to DT_L, or to LOW if dead_act=0.
  - DT_L: both 0. Mirror of DT_H, with target LOW and abort to HIGH when ref_q=1.
  - Any state with `en`=0: go to OFF on the next edge.
- dt_cnt clears on every entry to DT_H or DT_L.
- dead_act may change during a dead-time phase; the >= compare exits immediately if dt_cnt has already passed the new limit.
- Invariant: pwm_h and pwm_l are never both 1 in any cycle, including across reset, `en` toggles and updates.
- Latency: count<cmp first true at edge N gives ref_q at N+1, DT_H at N+2, and pwm_h=1 at N+2+dead_act.
- Async reset mid-operation: outputs drop to 0 immediately, without waiting for clk.

Decomposition:
- Shared package `timer_pkg` holds:
  - the state enum typedef `pwm_state_t` (OFF, LOW, DT_H, HIGH, DT_L);
  - a struct `pwm_cfg_t` {cmp, dead} for the staging and active registers;
  - the default WIDTH and DT_WIDTH constants.
- One natural sub-module: `pwm_shadow_reg`, holding the staging, pending and active registers plus the ack logic. The FSM and dead-time counter stay in the top module.

Test Plan:
1. Reset then `en`=1, dead_in=2, cmp_in=4, `upd_req` pulse, count cycling 15..0 with `done` at 0.
   - upd_busy=1 until the first `done`, then a single upd_ack pulse.
   - From the next period: pwm_h high while count<4, delayed 2 cycles.
   - Both outputs low for exactly 2 cycles at each edge.
2. cmp=0 → pwm_l stays constantly 1 and pwm_h stays 0. Then cmp=0xFFFF → pwm_h stays constantly 1 after the initial dead time.
3. dead=5 and a ref_q high pulse only 2 cycles long → FSM goes DT_H then back to LOW; pwm_h never asserts.
4. Two `upd_req` pulses (cmp 3 then 7) before `done` → only 7 is applied and only one upd_ack. Then `upd_req` coincident with `done` → the old value is applied, upd_busy stays 1, and the new value applies at the following `done`.
5. `en` dropped while in HIGH → OFF the next cycle, both outputs 0. Re-enable with dead=3 → 3 cycles in DT_L, then pwm_l=1.
6. Async reset asserted mid-HIGH between clock edges → pwm_h falls immediately and all outputs equal their reset values. Throughout all tests, an assertion checks !(pwm_h && pwm_l) every cycle.
